punc_control: RTL
=================

Name: punc_control

Overview:
- Control unit (FSM) for the PUnC LC3 processor; the other end of the datapath control interface.
- Consumes the instruction register and NZP flags from the datapath; drives every datapath load, enable, mux-select and register-address signal.
- Sequences INIT, FETCH, DECODE, EXEC and EXEC2 per LC3 opcode, and stops in HALT on TRAP x25.

Parameters:
- HALT_VECTOR, 8'h25, TRAP vector that halts the machine.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-low: rst==0 resets immediately regardless of clk.
- ir  in  16  current instruction register contents.
- nzp  in  3  {N,Z,P} condition flags.
- pc_clr  out  1  clear PC to 0.
- pc_inc  out  1  PC <= PC+1.
- pc_ld  out  1  load PC from pc_data_sel source.
- pc_data_sel  out  2  PC source: 0 PC+sext(off), 1 ALU result, 2 store register.
- pc_add_sel  out  1  PC adder offset: 0 sext(ir[10:0]), 1 sext(ir[8:0]).
- ir_ld  out  1  load IR from memory read data.
- mem_addr_sel  out  2  memory address: 0 PC, 1 ALU result, 2 store register.
- mem_w_en  out  1  memory write; data is RF read port 1.
- rf_r_addr_0  out  3  RF read address 0 (ALU A / base register).
- rf_r_addr_1  out  3  RF read address 1 (ALU B / store data).
- rf_w_addr  out  3  RF write address.
- rf_w_en  out  1  RF write enable.
- rf_w_sel  out  2  RF write data: 0 PC, 1 memory read data, 2 ALU result.
- a_sel  out  1  ALU A: 0 PC, 1 RF read data 0.
- b_sel  out  1  ALU B: 0 RF read data 1, 1 sign-extended immediate.
- sext_sel  out  2  immediate: 0 ir[4:0], 1 ir[5:0], 2 ir[8:0].
- alu_sel  out  2  0 ADD, 1 AND, 2 PASS_A, 3 NOT.
- nzp_sel  out  1  flag source: 0 ALU result, 1 memory read data.
- nzp_ld  out  1  update N, Z and P together.
- store_ld  out  1  load store register.
- store_sel  out  1  store register source: 0 ALU, 1 memory read data.
- halted  out  1  high while in HALT.

Behaviour:
- Outputs are Moore/decoded combinationally from state and ir. Every output is 0 unless listed for the current state. Memory read is combinational.
- Reset (rst==0): state=INIT. Outputs during reset: pc_clr=1, all others 0, halted=0.
- INIT: pc_clr=1 -> FETCH.
- FETCH: mem_addr_sel=0, ir_ld=1, pc_inc=1 -> DECODE. PC+offset math below therefore uses incremented PC.
- DECODE: no datapath writes. TRAP with ir[7:0]==HALT_VECTOR -> HALT; opcodes 1000/1101 and other TRAP vectors -> FETCH (NOP); all others -> EXEC.
- ADD(0001)/AND(0101):
  - A = R[ir[8:6]] (a_sel=1).
  - B = R[ir[2:0]], or sext5 if ir[5] (b_sel=1, sext_sel=0).
  - rf_w_sel=2, rf_w_en, rf_w_addr=ir[11:9], nzp_sel=0, nzp_ld.
- NOT(1001): alu_sel=3, A=R[ir[8:6]], write as ADD, nzp_ld.
- BR(0000): pc_ld=1 iff (ir[11]&N)|(ir[10]&Z)|(ir[9]&P); pc_data_sel=0, pc_add_sel=1. ir[11:9]==000 never branches.
- JMP(1100): A=R[ir[8:6]], alu_sel=2, pc_data_sel=1, pc_ld.
- JSR/JSRR(0100):
  - EXEC: if ir[11]==0, store_ld with ALU PASS_A of R[ir[8:6]].
  - EXEC2: rf_w_sel=0, rf_w_addr=7, rf_w_en, pc_ld with pc_data_sel=0/pc_add_sel=0 (ir[11]==1) or pc_data_sel=2.
  - Target is captured before the R7 write, so JSRR R7 jumps to the old R7.
- LD(0010)/LDR(0110):
  - Address = ALU ADD of PC+sext9 (a_sel=0, sext_sel=2) or R[ir[8:6]]+sext6.
  - mem_addr_sel=1, rf_w_sel=1, rf_w_en, nzp_sel=1, nzp_ld.
- LDI(1010):
  - EXEC: mem_addr_sel=1 (PC+sext9), store_sel=1, store_ld.
  - EXEC2: mem_addr_sel=2, rf write from memory, nzp_ld with nzp_sel=1.
- LEA(1110): rf write ALU PC+sext9; no nzp_ld.
- ST(0011)/STR(0111): address as LD/LDR, rf_r_addr_1=ir[11:9], mem_w_en.
- STI(1011):
  - EXEC: same as LDI EXEC.
  - EXEC2: mem_addr_sel=2, rf_r_addr_1=ir[11:9], mem_w_en.
- EXEC -> EXEC2 for JSR, LDI and STI; otherwise EXEC -> FETCH. EXEC2 -> FETCH.
- HALT: halted=1, no enables, remain until reset.
- Reset mid-instruction aborts it with no partial writes after the reset edge.
- Latency: 3 cycles per instruction (4 for JSR/LDI/STI); NOPs take 2.

Optional Feature:
- Macro PUNC_ILLEGAL_HALT_EN.
- Defined: opcodes 1000/1101 go DECODE -> HALT and assert output illegal_op (1 bit, held high in HALT, cleared by reset).
- Undefined: they are NOPs and the illegal_op port is absent.

Decomposition:
- Defines.v holds: opcode constants; state encodings (INIT/FETCH/DECODE/EXEC/EXEC2/HALT, 3 bits); all mux-select constants (PC source, address source, RF write source, ALU ops, sext widths).
- Optional sub-module punc_control_decode: combinational ir -> opcode class, branch-taken and sext_sel; FSM stays in punc_control.

Test Plan:
- Reset low then high -> pc_clr=1 during reset and for the INIT cycle; next cycle FETCH shows ir_ld=1, pc_inc=1, mem_addr_sel=0.
- ir=16'h1283 (ADD R1,R2,R3) -> EXEC shows rf_w_addr=1, rf_r_addr_0=2, rf_r_addr_1=3, b_sel=0, alu_sel=0, rf_w_en=1, nzp_ld=1; FETCH follows.
- ir=16'h0A05 (BRnp) with nzp=010 -> pc_ld=0; with nzp=100 -> pc_ld=1, pc_add_sel=1.
- ir=16'hA403 (LDI R2) -> EXEC store_sel=1, store_ld=1; EXEC2 mem_addr_sel=2, rf_w_addr=2, rf_w_sel=1, nzp_sel=1.
- ir=16'h41C0 (JSRR R7) -> EXEC store_ld via PASS_A of R7; EXEC2 rf_w_addr=7, rf_w_sel=0, pc_data_sel=2, pc_ld=1.
- ir=16'hF025 -> HALT, halted=1 indefinitely with all enables 0; ir=16'hF021 -> NOP back to FETCH; rst low in HALT -> INIT.

Source files
------------

// File: rtl/punc_control_pkg.sv
// Shared opcodes, FSM states and datapath mux encodings for the PUnC control unit.
package punc_control_pkg;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_RSV  = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_EXEC2  = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  localparam logic [1:0] PC_SRC_ADDER = 2'd0;
  localparam logic [1:0] PC_SRC_ALU   = 2'd1;
  localparam logic [1:0] PC_SRC_STORE = 2'd2;

  localparam logic PC_ADD_OFF11 = 1'b0;
  localparam logic PC_ADD_OFF9  = 1'b1;

  localparam logic [1:0] ADDR_PC    = 2'd0;
  localparam logic [1:0] ADDR_ALU   = 2'd1;
  localparam logic [1:0] ADDR_STORE = 2'd2;

  localparam logic [1:0] RFW_PC  = 2'd0;
  localparam logic [1:0] RFW_MEM = 2'd1;
  localparam logic [1:0] RFW_ALU = 2'd2;

  localparam logic A_PC  = 1'b0;
  localparam logic A_RF  = 1'b1;
  localparam logic B_RF  = 1'b0;
  localparam logic B_IMM = 1'b1;

  localparam logic [1:0] SEXT_5 = 2'd0;
  localparam logic [1:0] SEXT_6 = 2'd1;
  localparam logic [1:0] SEXT_9 = 2'd2;

  localparam logic [1:0] ALU_ADD    = 2'd0;
  localparam logic [1:0] ALU_AND    = 2'd1;
  localparam logic [1:0] ALU_PASS_A = 2'd2;
  localparam logic [1:0] ALU_NOT    = 2'd3;

  localparam logic NZP_ALU   = 1'b0;
  localparam logic NZP_MEM   = 1'b1;
  localparam logic STORE_ALU = 1'b0;
  localparam logic STORE_MEM = 1'b1;

endpackage

// File: rtl/punc_control_decode.sv
// Combinational instruction classifier: opcode class, branch condition and immediate width.
module punc_control_decode #(
  parameter logic [7:0] HALT_VECTOR = 8'h25
) (
  input  logic [15:0] ir_i,
  input  logic [2:0]  nzp_i,
  output logic [3:0]  opcode_o,
  output logic        halt_trap_o,
  output logic        illegal_o,
  output logic        nop_trap_o,
  output logic        two_cycle_o,
  output logic        br_taken_o,
  output logic [1:0]  sext_sel_o
);
  import punc_control_pkg::*;

  logic is_trap;

  assign opcode_o    = ir_i[15:12];
  assign is_trap     = (opcode_o == OP_TRAP);
  assign halt_trap_o = is_trap && (ir_i[7:0] == HALT_VECTOR);
  assign nop_trap_o  = is_trap && (ir_i[7:0] != HALT_VECTOR);
  assign illegal_o   = (opcode_o == OP_RTI) || (opcode_o == OP_RSV);
  assign two_cycle_o = (opcode_o == OP_JSR) || (opcode_o == OP_LDI) || (opcode_o == OP_STI);
  // A zero condition field never branches, since no flag bit can match it.
  assign br_taken_o  = |(ir_i[11:9] & nzp_i);

  always_comb begin
    sext_sel_o = SEXT_5;
    case (opcode_o)
      OP_LDR, OP_STR:                 sext_sel_o = SEXT_6;
      OP_LD, OP_ST, OP_LDI, OP_STI,
      OP_LEA:                         sext_sel_o = SEXT_9;
      default:                        sext_sel_o = SEXT_5;
    endcase
  end

endmodule

// File: rtl/punc_control.sv
// PUnC LC3 control FSM driving all datapath control lines.
// Optional macro PUNC_ILLEGAL_HALT_EN: opcodes 1000/1101 halt and raise illegal_op.
//
// state  | meaning
// INIT   | clear PC
// FETCH  | load IR from mem[PC], increment PC
// DECODE | classify instruction, no datapath writes
// EXEC   | first execute cycle
// EXEC2  | second execute cycle (JSR, LDI, STI)
// HALT   | stopped until reset
module punc_control #(
  parameter logic [7:0] HALT_VECTOR = 8'h25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic [2:0]  nzp,
  output logic        pc_clr,
  output logic        pc_inc,
  output logic        pc_ld,
  output logic [1:0]  pc_data_sel,
  output logic        pc_add_sel,
  output logic        ir_ld,
  output logic [1:0]  mem_addr_sel,
  output logic        mem_w_en,
  output logic [2:0]  rf_r_addr_0,
  output logic [2:0]  rf_r_addr_1,
  output logic [2:0]  rf_w_addr,
  output logic        rf_w_en,
  output logic [1:0]  rf_w_sel,
  output logic        a_sel,
  output logic        b_sel,
  output logic [1:0]  sext_sel,
  output logic [1:0]  alu_sel,
  output logic        nzp_sel,
  output logic        nzp_ld,
  output logic        store_ld,
  output logic        store_sel,
  output logic        halted
`ifdef PUNC_ILLEGAL_HALT_EN
  ,
  output logic        illegal_op
`endif
);
  import punc_control_pkg::*;

  state_e      state_q, state_d;
  logic [3:0]  opcode;
  logic        halt_trap, illegal, nop_trap, two_cycle, br_taken;
  logic [1:0]  sext_dec;
  logic [2:0]  dr, sr1;

  assign dr  = ir[11:9];
  assign sr1 = ir[8:6];

  punc_control_decode #(.HALT_VECTOR(HALT_VECTOR)) u_decode (
    .ir_i        (ir),
    .nzp_i       (nzp),
    .opcode_o    (opcode),
    .halt_trap_o (halt_trap),
    .illegal_o   (illegal),
    .nop_trap_o  (nop_trap),
    .two_cycle_o (two_cycle),
    .br_taken_o  (br_taken),
    .sext_sel_o  (sext_dec)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_INIT;
    else      state_q <= state_d;
  end

`ifdef PUNC_ILLEGAL_HALT_EN
  logic illegal_q, illegal_d;

  assign illegal_d  = illegal_q | ((state_q == ST_DECODE) & illegal);
  assign illegal_op = illegal_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) illegal_q <= 1'b0;
    else      illegal_q <= illegal_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:   state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        if (halt_trap)     state_d = ST_HALT;
`ifdef PUNC_ILLEGAL_HALT_EN
        else if (illegal)  state_d = ST_HALT;
`else
        else if (illegal)  state_d = ST_FETCH;
`endif
        else if (nop_trap) state_d = ST_FETCH;
        else               state_d = ST_EXEC;
      end
      ST_EXEC:   state_d = two_cycle ? ST_EXEC2 : ST_FETCH;
      ST_EXEC2:  state_d = ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_INIT;
    endcase
  end

  always_comb begin
    pc_clr       = 1'b0;
    pc_inc       = 1'b0;
    pc_ld        = 1'b0;
    pc_data_sel  = PC_SRC_ADDER;
    pc_add_sel   = PC_ADD_OFF11;
    ir_ld        = 1'b0;
    mem_addr_sel = ADDR_PC;
    mem_w_en     = 1'b0;
    rf_r_addr_0  = 3'd0;
    rf_r_addr_1  = 3'd0;
    rf_w_addr    = 3'd0;
    rf_w_en      = 1'b0;
    rf_w_sel     = RFW_PC;
    a_sel        = A_PC;
    b_sel        = B_RF;
    sext_sel     = SEXT_5;
    alu_sel      = ALU_ADD;
    nzp_sel      = NZP_ALU;
    nzp_ld       = 1'b0;
    store_ld     = 1'b0;
    store_sel    = STORE_ALU;
    halted       = 1'b0;

    case (state_q)
      ST_INIT:  pc_clr = 1'b1;
      ST_FETCH: begin
        ir_ld        = 1'b1;
        pc_inc       = 1'b1;
        mem_addr_sel = ADDR_PC;
      end
      ST_EXEC: begin
        case (opcode)
          OP_ADD, OP_AND, OP_NOT: begin
            a_sel       = A_RF;
            rf_r_addr_0 = sr1;
            if (opcode == OP_NOT) begin
              alu_sel = ALU_NOT;
            end else begin
              alu_sel = (opcode == OP_AND) ? ALU_AND : ALU_ADD;
              if (ir[5]) begin
                b_sel    = B_IMM;
                sext_sel = sext_dec;
              end else begin
                rf_r_addr_1 = ir[2:0];
              end
            end
            rf_w_sel  = RFW_ALU;
            rf_w_en   = 1'b1;
            rf_w_addr = dr;
            nzp_sel   = NZP_ALU;
            nzp_ld    = 1'b1;
          end
          OP_BR: begin
            pc_ld       = br_taken;
            pc_data_sel = PC_SRC_ADDER;
            pc_add_sel  = PC_ADD_OFF9;
          end
          OP_JMP: begin
            a_sel       = A_RF;
            rf_r_addr_0 = sr1;
            alu_sel     = ALU_PASS_A;
            pc_data_sel = PC_SRC_ALU;
            pc_ld       = 1'b1;
          end
          OP_JSR: begin
            // Capture the JSRR target now so a later R7 write cannot disturb it.
            if (!ir[11]) begin
              a_sel       = A_RF;
              rf_r_addr_0 = sr1;
              alu_sel     = ALU_PASS_A;
              store_sel   = STORE_ALU;
              store_ld    = 1'b1;
            end
          end
          OP_LD, OP_LDR, OP_ST, OP_STR: begin
            b_sel        = B_IMM;
            sext_sel     = sext_dec;
            alu_sel      = ALU_ADD;
            mem_addr_sel = ADDR_ALU;
            if (opcode == OP_LDR || opcode == OP_STR) begin
              a_sel       = A_RF;
              rf_r_addr_0 = sr1;
            end
            if (opcode == OP_LD || opcode == OP_LDR) begin
              rf_w_sel  = RFW_MEM;
              rf_w_en   = 1'b1;
              rf_w_addr = dr;
              nzp_sel   = NZP_MEM;
              nzp_ld    = 1'b1;
            end else begin
              rf_r_addr_1 = dr;
              mem_w_en    = 1'b1;
            end
          end
          OP_LDI, OP_STI: begin
            b_sel        = B_IMM;
            sext_sel     = sext_dec;
            alu_sel      = ALU_ADD;
            mem_addr_sel = ADDR_ALU;
            store_sel    = STORE_MEM;
            store_ld     = 1'b1;
          end
          OP_LEA: begin
            b_sel     = B_IMM;
            sext_sel  = sext_dec;
            alu_sel   = ALU_ADD;
            rf_w_sel  = RFW_ALU;
            rf_w_en   = 1'b1;
            rf_w_addr = dr;
          end
          default: ;
        endcase
      end
      ST_EXEC2: begin
        case (opcode)
          OP_JSR: begin
            rf_w_sel    = RFW_PC;
            rf_w_addr   = 3'd7;
            rf_w_en     = 1'b1;
            pc_ld       = 1'b1;
            pc_data_sel = ir[11] ? PC_SRC_ADDER : PC_SRC_STORE;
            pc_add_sel  = PC_ADD_OFF11;
          end
          OP_LDI: begin
            mem_addr_sel = ADDR_STORE;
            rf_w_sel     = RFW_MEM;
            rf_w_en      = 1'b1;
            rf_w_addr    = dr;
            nzp_sel      = NZP_MEM;
            nzp_ld       = 1'b1;
          end
          OP_STI: begin
            mem_addr_sel = ADDR_STORE;
            rf_r_addr_1  = dr;
            mem_w_en     = 1'b1;
          end
          default: ;
        endcase
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule
